// File: rtl/bp_pkg.sv
// Shared types for the branch predictor update path.
// Used by the update scheduler and the predictor-side wiring.
package bp_pkg;

    localparam int BP_ADDR_W  = 5;
    localparam int BP_ENTRIES = 32;

    typedef struct packed {
        logic [BP_ADDR_W-1:0] addr;
        logic                 taken;
    } bp_upd_t;

endpackage

// File: rtl/bp_update_fifo.sv
// Two-write / one-read circular buffer of predictor updates.
// Write port 0 is always ordered ahead of write port 1 in the same cycle.
module bp_update_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             push0_i,
    input  bp_upd_t          push0_data_i,
    input  logic             push1_i,
    input  bp_upd_t          push1_data_i,
    input  logic             pop_i,
    output bp_upd_t          head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    bp_upd_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_wr1_idx;

    // Port 1 lands right behind port 0 when both push, otherwise at the write pointer.
    assign w_wr1_idx = r_wptr + PTR_W'(push0_i);

    // NOTE: storage has no reset; the pointers and count decide which entries are valid.
    always_ff @(posedge clk_i) begin
        if (!flush_i) begin
            if (push0_i) r_mem[r_wptr]    <= push0_data_i;
            if (push1_i) r_mem[w_wr1_idx] <= push1_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PTR_W'(push0_i) + PTR_W'(push1_i);
            r_rptr  <= r_rptr + PTR_W'(pop_i);
            r_count <= r_count + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
        end
    end

    assign head_o  = r_mem[r_rptr];
    assign count_o = r_count;

endmodule

// File: rtl/branch_update_scheduler.sv
// Merges two branch resolution streams into the single predictor update port.
// Readiness is based on registered occupancy only, so a same-cycle pop never frees space.
module branch_update_scheduler
    import bp_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(BP_ENTRIES),
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              res0_valid_i,
    input  logic [ADDR_W-1:0] res0_addr_i,
    input  logic              res0_taken_i,
    output logic              res0_ready_o,
    input  logic              res1_valid_i,
    input  logic [ADDR_W-1:0] res1_addr_i,
    input  logic              res1_taken_i,
    output logic              res1_ready_o,
    input  logic              flush_i,
    input  logic              upd_hold_i,
    output logic              upd_en_o,
    output logic [ADDR_W-1:0] upd_addr_o,
    output logic              upd_taken_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_free;
    logic             w_ready0;
    logic             w_ready1;
    logic             w_push0;
    logic             w_push1;
    logic             w_pop;
    logic             w_nonempty;
    bp_upd_t          w_wr0;
    bp_upd_t          w_wr1;
    bp_upd_t          w_head;

    assign w_free     = CNT_W'(DEPTH) - w_count;
    assign w_nonempty = (w_count != '0);

    // Port 1 looks at res0_valid_i rather than res0's ready, which keeps the readies loop-free.
    assign w_ready0 = !flush_i && (w_free >= CNT_W'(1));
    assign w_ready1 = !flush_i && ((w_free >= CNT_W'(2)) ||
                                   ((w_free == CNT_W'(1)) && !res0_valid_i));

    assign w_push0 = res0_valid_i && w_ready0;
    assign w_push1 = res1_valid_i && w_ready1;
    assign w_pop   = w_nonempty && !upd_hold_i && !flush_i;

    assign w_wr0 = {res0_addr_i, res0_taken_i};
    assign w_wr1 = {res1_addr_i, res1_taken_i};

    bp_update_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .flush_i      (flush_i),
        .push0_i      (w_push0),
        .push0_data_i (w_wr0),
        .push1_i      (w_push1),
        .push1_data_i (w_wr1),
        .pop_i        (w_pop),
        .head_o       (w_head),
        .count_o      (w_count)
    );

    assign res0_ready_o = w_ready0;
    assign res1_ready_o = w_ready1;
    assign upd_en_o     = w_pop;
    assign upd_addr_o   = w_nonempty ? w_head.addr : '0;
    assign upd_taken_o  = w_nonempty ? w_head.taken : 1'b0;
    assign count_o      = w_count;

endmodule

// File: tb/tb_branch_update_scheduler.sv
// Scoreboard bench: the driver queues accepted resolutions, a monitor checks every drained update.
// Directed scenarios first, then randomized traffic with hold-heavy and drain-heavy phases.
module tb_branch_update_scheduler;
    import bp_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 3;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              res0_valid_i;
    logic [ADDR_W-1:0] res0_addr_i;
    logic              res0_taken_i;
    logic              res0_ready_o;
    logic              res1_valid_i;
    logic [ADDR_W-1:0] res1_addr_i;
    logic              res1_taken_i;
    logic              res1_ready_o;
    logic              flush_i;
    logic              upd_hold_i;
    logic              upd_en_o;
    logic [ADDR_W-1:0] upd_addr_o;
    logic              upd_taken_o;
    logic [CNT_W-1:0]  count_o;

    bp_upd_t sb[$];
    int      total  = 0;
    int      bad    = 0;
    bit      mon_on = 1'b0;

    branch_update_scheduler #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .res0_valid_i (res0_valid_i),
        .res0_addr_i  (res0_addr_i),
        .res0_taken_i (res0_taken_i),
        .res0_ready_o (res0_ready_o),
        .res1_valid_i (res1_valid_i),
        .res1_addr_i  (res1_addr_i),
        .res1_taken_i (res1_taken_i),
        .res1_ready_o (res1_ready_o),
        .flush_i      (flush_i),
        .upd_hold_i   (upd_hold_i),
        .upd_en_o     (upd_en_o),
        .upd_addr_o   (upd_addr_o),
        .upd_taken_o  (upd_taken_o),
        .count_o      (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; readies are predicted from the number of queued resolutions.
    task automatic drive(input bit v0, input int a0, input bit t0,
                         input bit v1, input int a1, input bit t1,
                         input bit fl, input bit hd);
        int      free;
        bit      e0;
        bit      e1;
        bp_upd_t x;
        @(negedge clk_i);
        res0_valid_i = v0;
        res0_addr_i  = ADDR_W'(a0);
        res0_taken_i = t0;
        res1_valid_i = v1;
        res1_addr_i  = ADDR_W'(a1);
        res1_taken_i = t1;
        flush_i      = fl;
        upd_hold_i   = hd;
        #1;
        free = DEPTH - sb.size();
        e0   = !fl && (free >= 1);
        e1   = !fl && ((free >= 2) || ((free == 1) && !v0));
        check("res0_ready", res0_ready_o, e0);
        check("res1_ready", res1_ready_o, e1);
        @(posedge clk_i);
        if (fl) begin
            sb.delete();
        end else begin
            if (v0 && e0) begin
                x.addr  = ADDR_W'(a0);
                x.taken = t0;
                sb.push_back(x);
            end
            if (v1 && e1) begin
                x.addr  = ADDR_W'(a1);
                x.taken = t1;
                sb.push_back(x);
            end
        end
    endtask

    task automatic idle(input bit hd);
        drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, hd);
    endtask

    // Monitor: the model head must appear on upd_*, and is consumed whenever an update is due.
    initial begin
        bit exp_en;
        forever begin
            @(negedge clk_i);
            #2;
            if (mon_on) begin
                exp_en = (sb.size() != 0) && !upd_hold_i && !flush_i;
                check("upd_en", upd_en_o, exp_en);
                check("count", count_o, sb.size());
                if (sb.size() != 0) begin
                    check("upd_addr", upd_addr_o, sb[0].addr);
                    check("upd_taken", upd_taken_o, sb[0].taken);
                end else begin
                    check("upd_addr_empty", upd_addr_o, 0);
                    check("upd_taken_empty", upd_taken_o, 0);
                end
                if (exp_en) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hold_phase;
        reset_i      = 1'b1;
        res0_valid_i = 1'b0;
        res0_addr_i  = '0;
        res0_taken_i = 1'b0;
        res1_valid_i = 1'b0;
        res1_addr_i  = '0;
        res1_taken_i = 1'b0;
        flush_i      = 1'b0;
        upd_hold_i   = 1'b0;
        #12;
        check("rst_count", count_o, 0);
        check("rst_upd_en", upd_en_o, 0);
        check("rst_upd_addr", upd_addr_o, 0);
        check("rst_upd_taken", upd_taken_o, 0);
        check("rst_ready0", res0_ready_o, 1);
        check("rst_ready1", res1_ready_o, 1);
        @(negedge clk_i);
        reset_i = 1'b0;
        mon_on  = 1'b1;

        // Single resolution, then a dual one drained in port order.
        drive(1'b1, 3, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        drive(1'b1, 7, 1'b0, 1'b1, 12, 1'b1, 1'b0, 1'b0);
        repeat (3) idle(1'b0);

        // Fill under hold, attempt a push while full, then release.
        drive(1'b1, 1, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 3, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 5, 1'b1, 1'b1, 6, 1'b1, 1'b0, 1'b1);
        repeat (6) idle(1'b0);

        // Occupancy 3 with both valid: only res0 fits; then flush with 3 queued.
        drive(1'b1, 8, 1'b1, 1'b1, 9, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 10, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 11, 1'b0, 1'b1, 13, 1'b1, 1'b0, 1'b1);
        idle(1'b0);
        drive(1'b1, 14, 1'b1, 1'b1, 15, 1'b0, 1'b1, 1'b0);
        repeat (3) idle(1'b0);

        // Asynchronous reset in the middle of a cycle with two entries queued.
        drive(1'b1, 20, 1'b1, 1'b1, 21, 1'b0, 1'b0, 1'b1);
        @(negedge clk_i);
        mon_on       = 1'b0;
        res0_valid_i = 1'b0;
        res1_valid_i = 1'b0;
        upd_hold_i   = 1'b0;
        #1;
        check("pre_reset_upd_en", upd_en_o, 1);
        check("pre_reset_count", count_o, 2);
        #2;
        reset_i = 1'b1;
        #1;
        check("async_rst_count", count_o, 0);
        check("async_rst_upd_en", upd_en_o, 0);
        check("async_rst_ready0", res0_ready_o, 1);
        sb.delete();
        @(negedge clk_i);
        reset_i = 1'b0;
        mon_on  = 1'b1;
        repeat (2) idle(1'b0);

        // Randomized traffic alternating between hold-heavy and drain-heavy phases.
        for (int i = 0; i < 400; i++) begin
            hold_phase = ((i / 40) % 2) == 1;
            drive($urandom_range(0, 2) != 0, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) != 0, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 24) == 0,
                  hold_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0));
        end

        for (int i = 0; i < 10; i++) begin
            if (sb.size() != 0) idle(1'b0);
        end
        idle(1'b0);
        check("final_count", count_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_update_scheduler.md
Name: branch_update_scheduler

Overview:
Sequences branch-resolution updates into the 32-entry branch prediction table, which has a single update port. Two branch execution units can each resolve one branch per cycle. The block accepts both resolutions, buffers them in order in a small circular queue, and drains one update per cycle into the predictor's write address, taken and update-enable inputs. It sits between the branch execution units and the predictor. It also supports flush (squash of wrong-path resolutions) and a hold from the predictor side.

Parameters:
DEPTH, 4, queue entries; power of two, at least 2
ADDR_W, 5, predictor index width (32 entries)
CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
clk_i  in  1  clock; all state updates on rising edge
reset_i  in  1  asynchronous, active-high reset
res0_valid_i  in  1  execution unit 0 has a resolved branch
res0_addr_i  in  ADDR_W  predictor index of branch 0
res0_taken_i  in  1  branch 0 outcome, 1 = taken
res0_ready_o  out  1  scheduler can accept branch 0 this cycle
res1_valid_i  in  1  execution unit 1 has a resolved branch
res1_addr_i  in  ADDR_W  predictor index of branch 1
res1_taken_i  in  1  branch 1 outcome
res1_ready_o  out  1  scheduler can accept branch 1 this cycle
flush_i  in  1  discard all queued and same-cycle resolutions
upd_hold_i  in  1  predictor cannot take an update this cycle
upd_en_o  out  1  update strobe to predictor
upd_addr_o  out  ADDR_W  predictor write index
upd_taken_o  out  1  outcome applied to the indexed state machine
count_o  out  CNT_W  current queue occupancy

Behaviour:
- Reset (async, while reset_i=1):
  - Write and read pointers = 0, count = 0.
  - upd_en_o = 0, upd_addr_o = 0, upd_taken_o = 0, count_o = 0.
  - res0_ready_o and res1_ready_o = 1 (queue empty).
  - Deassertion mid-stream: queue restarts empty; no partial update is issued.
- Acceptance:
  - Handshake fires when valid & ready in the same cycle. Data is sampled at that rising edge.
  - free = DEPTH - count, computed from registered count only; a same-cycle pop does not create space.
  - res0_ready_o = !flush_i & (free >= 1).
  - res1_ready_o = !flush_i & ((free >= 2) | (free == 1 & !res0_valid_i)).
  - Readies do not depend on each other's ready, only on res0_valid_i, so there is no combinational loop.
- Ordering:
  - When both requesters are accepted in one cycle, res0 is written at wptr and res1 at wptr+1; wptr advances by 2.
  - A single acceptance writes at wptr; wptr advances by 1.
  - Pointers wrap modulo DEPTH.
- Drain:
  - upd_en_o = (count != 0) & !upd_hold_i & !flush_i, combinational from registered state.
  - upd_addr_o and upd_taken_o always show the queue head; they are 0 when empty.
  - A pop occurs at the edge where upd_en_o = 1: rptr+1 and the head is consumed.
  - Latency: a resolution accepted at edge N is driven on upd_* during cycle N+1 if the queue was empty and no hold is asserted.
- Count:
  - next count = count + accepted(0..2) - pop(0..1).
  - Simultaneous push and pop on a full queue is legal only via the pop; no acceptance occurs because free = 0.
  - Overflow and underflow are impossible by construction. The verifier asserts 0 <= count <= DEPTH.
- Flush:
  - At the edge with flush_i = 1: pointers and count go to 0.
  - Same-cycle inputs are dropped (readies are 0) and no update is issued (upd_en_o = 0).
  - flush_i has priority over hold, push and pop.
- Hold: while upd_hold_i = 1, the head is stable and acceptance continues until full.
- Duplicate addresses in the queue are legal. Each entry is applied in order; there is no merging.

Decomposition:
- Package bp_pkg:
  - BP_ADDR_W = 5, BP_ENTRIES = 32.
  - Typedef bp_upd_t {logic [BP_ADDR_W-1:0] addr; logic taken;}, shared with the predictor-side wiring.
- Sub-module bp_update_fifo: parameterised 2-write/1-read circular buffer holding storage, pointers and count.
- The top level holds the ready logic, flush/hold gating and the output strobe.

Test Plan:
- Reset, then res0 only: addr=3, taken=1 for one cycle.
  -> next cycle upd_en_o=1, upd_addr_o=3, upd_taken_o=1; following cycle count_o=0, upd_en_o=0.
- Both valid in one cycle: res0 (addr=7, t=0) and res1 (addr=12, t=1).
  -> two consecutive upd_en_o cycles in the order 7/0 then 12/1.
- Fill with upd_hold_i=1: DEPTH=4, two double-pushes.
  -> count_o=4, both readies 0.
  -> release hold: four updates in push order.
  -> res0_ready_o returns 1 in the cycle after the first pop.
- count=3 (free=1), both valid.
  -> res0_ready_o=1, res1_ready_o=0; only res0 enqueued; count_o=4.
- Queue holding 3 entries, flush_i for 1 cycle with both valid.
  -> upd_en_o=0 that cycle, readies 0, count_o=0 afterwards, no further updates.
- Async reset asserted mid-clock with 2 entries queued.
  -> count_o=0 and upd_en_o=0 immediately, without a clock edge.
